// File: rtl/shift_serializer_tx.sv
// shift_serializer_tx: parallel-to-serial transmitter feeding the 4-bit shift
// register link. Frames each word as start, WIDTH data bits (LSB- or
// MSB-first), optional even parity, and stop.
// Optional feature: define PARITY_EN to insert an even-parity bit after the data.
module shift_serializer_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             direction,
  output logic             serial_out,
  output logic             dir_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = $clog2(WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  BIT_ONE   = CNT_W'(1);
  // With one clk per bit, the first cycle of a period is also its last.
  localparam logic              ONE_CLK   = 1'(CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BAUD_W-1:0]  baud_cnt;
  logic               baud_last;
  logic               baud_next_last;
`ifdef PARITY_EN
  logic               parity_bit;
`endif

  // NOTE: data_ready is a pure decode of the state register, so it carries no
  // path from the inputs even though it is not a flop of its own.
  assign data_ready     = (state == IDLE);
  assign baud_last      = (baud_cnt == BAUD_LAST);
  // Strobe and done are registered, so they are raised one cycle early: when
  // the counter is about to step into the last clk of the period.
  assign baud_next_last = ((baud_cnt + BAUD_ONE) == BAUD_LAST);

  // Frame sequencer: state, counters, shift register and all registered outputs.
  // NOTE: every assignment in this clocked block is non-blocking so that all
  // right-hand sides see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      baud_cnt   <= '0;
      serial_out <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      bit_strobe <= 1'b0;
      dir_out    <= 1'b0;
`ifdef PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      done       <= 1'b0;
      bit_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (data_valid) begin
            state      <= START;
            shreg      <= data_in;
            dir_out    <= direction;
            bit_cnt    <= '0;
            baud_cnt   <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b1;
`ifdef PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
        end

        START: begin
          if (baud_last) begin
            state      <= DATA;
            baud_cnt   <= '0;
            serial_out <= dir_out ? shreg[WIDTH-1] : shreg[0];
            bit_strobe <= ONE_CLK;
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        DATA: begin
          if (!baud_last) begin
            baud_cnt   <= baud_cnt + BAUD_ONE;
            bit_strobe <= baud_next_last;
          end else begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef PARITY_EN
              state      <= PARITY;
              serial_out <= parity_bit;
`else
              state      <= STOP;
              serial_out <= 1'b1;
              done       <= ONE_CLK;
`endif
            end else begin
              bit_cnt    <= bit_cnt + BIT_ONE;
              bit_strobe <= ONE_CLK;
              // The bit adjacent to the one just sent becomes the new line value.
              if (dir_out) begin
                serial_out <= shreg[WIDTH-2];
                shreg      <= {shreg[WIDTH-2:0], 1'b0};
              end else begin
                serial_out <= shreg[1];
                shreg      <= {1'b0, shreg[WIDTH-1:1]};
              end
            end
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          if (!baud_last) begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end else begin
            baud_cnt   <= '0;
            state      <= STOP;
            serial_out <= 1'b1;
            done       <= ONE_CLK;
          end
        end
`endif

        STOP: begin
          if (!baud_last) begin
            baud_cnt <= baud_cnt + BAUD_ONE;
            done     <= baud_next_last;
          end else begin
            baud_cnt <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
